sorter_ctrl: RTL and testbench

- Bubble-sort sequencing FSM for the 256 x 16-bit sorter datapath: memory, operand registers D1/D2, magnitude comparator, write-back mux.
- Issues memory read/write strobes, address, register load enables and compare strobe.
- Consumes only the comparator result; holds no data-width state.
- Sits between the top-level start/done handshake and the sorter datapath.

---
 rtl/sorter_ctrl.sv | 135 +++++++++++++
 tb/tb_sorter_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorter_ctrl.sv
// Bubble-sort sequencing FSM for the sorter datapath; drives memory strobes, address and D1/D2 loads.
// Optional: define SORTER_EARLY_EXIT_EN to finish after the first pass that performs no swap.
module sorter_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N      = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              gt,
    output logic              busy,
    output logic              done,
    output logic              read_mem,
    output logic              write_mem,
    output logic              ld_d1,
    output logic              ld_d2,
    output logic              sel_wr,
    output logic              cmp,
    output logic [ADDR_W-1:0] addr
);

    typedef enum logic [2:0] {
        StIdle, StLd1, StLd2, StCmp, StWr1, StWr2, StPass, StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LimInit = ADDR_W'(N - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] lim_q, lim_d;
    logic              swapped_q, swapped_d;
    logic [ADDR_W:0]   i_inc;
    logic              more;
    logic              last_pass;

    // One extra bit so i+1 reaches 2**ADDR_W without wrapping when N is the full depth.
    assign i_inc = {1'b0, i_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign more  = i_inc < {1'b0, lim_q};

`ifdef SORTER_EARLY_EXIT_EN
    assign last_pass = (lim_q == ADDR_W'(1)) || !swapped_q;
`else
    assign last_pass = (lim_q == ADDR_W'(1));
`endif

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        lim_d     = lim_q;
        swapped_d = swapped_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLd1;
                    i_d       = '0;
                    lim_d     = LimInit;
                    swapped_d = 1'b0;
                end
            end
            StLd1: state_d = StLd2;
            StLd2: state_d = StCmp;
            StCmp: begin
                if (gt) begin
                    state_d   = StWr1;
                    swapped_d = 1'b1;
                end else if (more) begin
                    state_d = StLd1;
                    i_d     = i_inc[ADDR_W-1:0];
                end else begin
                    state_d = StPass;
                end
            end
            StWr1: state_d = StWr2;
            StWr2: begin
                if (more) begin
                    state_d = StLd1;
                    i_d     = i_inc[ADDR_W-1:0];
                end else begin
                    state_d = StPass;
                end
            end
            StPass: begin
                if (last_pass) begin
                    state_d = StDone;
                end else begin
                    state_d   = StLd1;
                    lim_d     = lim_q - ADDR_W'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            i_q       <= '0;
            lim_q     <= '0;
            swapped_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_mem  <= 1'b0;
            write_mem <= 1'b0;
            ld_d1     <= 1'b0;
            ld_d2     <= 1'b0;
            sel_wr    <= 1'b0;
            cmp       <= 1'b0;
            addr      <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            lim_q     <= lim_d;
            swapped_q <= swapped_d;
            busy      <= (state_d != StIdle) && (state_d != StDone);
            done      <= (state_d == StDone);
            read_mem  <= (state_d == StLd1) || (state_d == StLd2);
            write_mem <= (state_d == StWr1) || (state_d == StWr2);
            ld_d1     <= (state_d == StLd1);
            ld_d2     <= (state_d == StLd2);
            sel_wr    <= (state_d == StWr1);
            cmp       <= (state_d == StCmp);
            if ((state_d == StLd1) || (state_d == StWr1)) begin
                addr <= i_d;
            end else if ((state_d == StLd2) || (state_d == StWr2)) begin
                addr <= i_d + ADDR_W'(1);
            end else begin
                addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sorter_ctrl.sv
// Self-checking bench for sorter_ctrl: three controllers (N=4, N=32 full depth, N=256) each with
// a behavioural memory/D1/D2/comparator datapath; sorted results checked through a scoreboard queue.
module tb_sorter_ctrl;

    localparam int NI = 3;

`ifdef SORTER_EARLY_EXIT_EN
    localparam int SortedLat = 10;
`else
    localparam int SortedLat = 21;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start     [NI];
    logic        gt        [NI];
    logic        busy      [NI];
    logic        done      [NI];
    logic        read_mem  [NI];
    logic        write_mem [NI];
    logic        ld_d1     [NI];
    logic        ld_d2     [NI];
    logic        sel_wr    [NI];
    logic        cmp       [NI];
    logic [7:0]  addr      [NI];
    logic [15:0] mem       [NI][256];
    logic [15:0] img       [NI][256];
    logic [15:0] d1        [NI];
    logic [15:0] d2        [NI];
    logic        load      [NI];
    logic        clr       [NI];
    logic        nogt_q    [NI];
    int          wr_cnt    [NI];
    int          bad_wr    [NI];
    int          bad_addr  [NI];
    int          max_addr  [NI];
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int unsigned AK = (k == 1) ? 5 : 8;
        localparam int unsigned NK = (k == 0) ? 4 : ((k == 1) ? 32 : 256);
        logic [AK-1:0] a;
        sorter_ctrl #(.ADDR_W(AK), .N(NK)) u_dut (
            .clk(clk), .rst(rst), .start(start[k]), .gt(gt[k]), .busy(busy[k]), .done(done[k]),
            .read_mem(read_mem[k]), .write_mem(write_mem[k]), .ld_d1(ld_d1[k]), .ld_d2(ld_d2[k]),
            .sel_wr(sel_wr[k]), .cmp(cmp[k]), .addr(a)
        );
        assign addr[k] = 8'(a);
    end

    always_comb begin
        for (int k = 0; k < NI; k++) gt[k] = d1[k] > d2[k];
    end

    function automatic int n_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 32 : 256);
    endfunction

    // Datapath model plus protocol monitors.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (load[k]) begin
                for (int j = 0; j < 256; j++) mem[k][j] <= img[k][j];
            end else if (write_mem[k]) begin
                mem[k][addr[k]] <= sel_wr[k] ? d2[k] : d1[k];
            end
            if (ld_d1[k]) d1[k] <= mem[k][addr[k]];
            if (ld_d2[k]) d2[k] <= mem[k][addr[k]];
            if (clr[k]) begin
                wr_cnt[k]   <= 0;
                bad_wr[k]   <= 0;
                bad_addr[k] <= 0;
                max_addr[k] <= 0;
            end else begin
                if (write_mem[k]) wr_cnt[k] <= wr_cnt[k] + 1;
                if (nogt_q[k] && write_mem[k]) bad_wr[k] <= bad_wr[k] + 1;
                if (((read_mem[k] || write_mem[k]) && int'(addr[k]) >= n_of(k)) ||
                    (ld_d2[k] && addr[k] == 8'd0))
                    bad_addr[k] <= bad_addr[k] + 1;
                if ((read_mem[k] || write_mem[k]) && int'(addr[k]) > max_addr[k])
                    max_addr[k] <= int'(addr[k]);
            end
            nogt_q[k] <= cmp[k] && !gt[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_img(input int k);
        @(negedge clk);
        load[k] = 1'b1;
        @(negedge clk);
        load[k] = 1'b0;
    endtask

    task automatic push_exp(input int k);
        logic [15:0] s[$];
        logic [15:0] t;
        for (int j = 0; j < n_of(k); j++) s.push_back(img[k][j]);
        for (int p = 1; p < s.size(); p++) begin
            for (int q = p; q > 0 && s[q-1] > s[q]; q--) begin
                t = s[q]; s[q] = s[q-1]; s[q-1] = t;
            end
        end
        for (int j = 0; j < s.size(); j++) exp_q.push_back(s[j]);
    endtask

    task automatic check_mem(input int k, input string tag);
        logic [15:0] e;
        for (int j = 0; j < n_of(k); j++) begin
            e = exp_q.pop_front();
            check(tag, 32'(mem[k][j]), 32'(e));
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        check(tag, {21'd0, busy[k], done[k], read_mem[k], write_mem[k], ld_d1[k], ld_d2[k],
                    sel_wr[k], cmp[k], addr[k] != 8'd0}, 32'd0);
    endtask

    // Latency = edges after the start-sampling edge E0 until done is seen.
    task automatic run_sort(input int k, input int pulse_at, input int limit, output int lat);
        int cnt;
        @(negedge clk);
        start[k] = 1'b1;
        clr[k]   = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        clr[k]   = 1'b0;
        check("first_ld1", {busy[k], read_mem[k], ld_d1[k], addr[k]}, {1'b1, 1'b1, 1'b1, 8'd0});
        cnt = 1;
        while (!done[k] && cnt < limit) begin
            @(negedge clk);
            cnt++;
            start[k] = (cnt == pulse_at);
        end
        start[k] = 1'b0;
        check("done_reached", 32'(done[k]), 32'd1);
        lat = cnt - 1;
    endtask

    initial begin
        int lat;
        int w;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            load[k]  = 1'b0;
            clr[k]   = 1'b0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) check_idle(k, "reset_outputs");
        rst = 1'b1;

        // Sorted input
        img[0][0] = 16'd1; img[0][1] = 16'd2; img[0][2] = 16'd3; img[0][3] = 16'd4;
        load_img(0);
        push_exp(0);
        run_sort(0, 0, 200, lat);
        check("sorted_latency", 32'(lat), 32'(SortedLat));
        check("sorted_no_write", 32'(wr_cnt[0]), 32'd0);
        check_mem(0, "sorted_mem");

        // start held in DONE restarts immediately with identical latency
        push_exp(0);
        run_sort(0, 0, 200, lat);
        check("restart_latency", 32'(lat), 32'(SortedLat));
        check_mem(0, "restart_mem");

        // Reverse input
        img[0][0] = 16'd4; img[0][1] = 16'd3; img[0][2] = 16'd2; img[0][3] = 16'd1;
        load_img(0);
        push_exp(0);
        run_sort(0, 0, 200, lat);
        check("reverse_latency", 32'(lat), 32'd33);
        check("reverse_writes", 32'(wr_cnt[0]), 32'd12);
        check_mem(0, "reverse_mem");

        // Duplicates: equal operands never swap
        img[0][0] = 16'd2; img[0][1] = 16'd2; img[0][2] = 16'd1; img[0][3] = 16'd2;
        load_img(0);
        push_exp(0);
        run_sort(0, 0, 200, lat);
        check("dup_latency", 32'(lat), 32'd25);
        check("dup_writes", 32'(wr_cnt[0]), 32'd4);
        check("dup_no_swap_equal", 32'(bad_wr[0]), 32'd0);
        check_mem(0, "dup_mem");

        // start pulsed while busy is ignored
        img[0][0] = 16'd4; img[0][1] = 16'd3; img[0][2] = 16'd2; img[0][3] = 16'd1;
        load_img(0);
        push_exp(0);
        run_sort(0, 6, 200, lat);
        check("busy_start_latency", 32'(lat), 32'd33);
        check_mem(0, "busy_start_mem");

        // Reset mid-sort while in WR1
        load_img(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        w = 0;
        while (!(write_mem[0] && sel_wr[0]) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("reach_wr1", 32'(write_mem[0] && sel_wr[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "midsort_reset_1");
        @(negedge clk);
        check_idle(0, "midsort_reset_2");
        rst = 1'b1;
        load_img(0);
        push_exp(0);
        run_sort(0, 0, 200, lat);
        check("post_reset_latency", 32'(lat), 32'd33);
        check_mem(0, "post_reset_mem");

        // Full-depth controller (N = 2**ADDR_W), random data with extremes
        for (int j = 0; j < 256; j++) img[1][j] = 16'($urandom);
        img[1][3]  = 16'h0000;
        img[1][17] = 16'hFFFF;
        load_img(1);
        push_exp(1);
        run_sort(1, 0, 20000, lat);
        check_mem(1, "full32_mem");
        check("full32_addr_ok", 32'(bad_addr[1]), 32'd0);
        check("full32_max_addr", 32'(max_addr[1]), 32'd31);
        check("full32_no_swap_equal", 32'(bad_wr[1]), 32'd0);

        // N=256: first pass must bubble the maximum to entry 255 without address wrap
        for (int j = 0; j < 256; j++) img[2][j] = 16'($urandom);
        img[2][0]   = 16'hFFFF;
        img[2][100] = 16'h0000;
        load_img(2);
        @(negedge clk);
        start[2] = 1'b1;
        clr[2]   = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        clr[2]   = 1'b0;
        w = 0;
        while (!(busy[2] && !read_mem[2] && !write_mem[2] && !cmp[2]) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("n256_reach_pass", 32'(busy[2] && !read_mem[2] && !write_mem[2] && !cmp[2]), 32'd1);
        check("n256_max_bubbled", 32'(mem[2][255]), 32'hFFFF);
        check("n256_addr_ok", 32'(bad_addr[2]), 32'd0);
        check("n256_max_addr", 32'(max_addr[2]), 32'd255);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle(2, "n256_reset");
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
